div_issue_ctrl: RTL and testbench

- Front-end controller for the 45-cycle pipelined 40-bit signed divider in the MDU.
- Takes MIPS DIV/DIVU requests from the execute stage and extends the 32-bit operands to 40 bits. It issues exactly one operation at a time to the divider.
- Waits for the divider's result, then returns HI (remainder) and LO (quotient) with a valid/ready handshake.
- Handles the cases the divider cannot: divide-by-zero, flush of an in-flight operation, and a lost result (timeout).

---
 rtl/div_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_div_issue_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// Issue controller for the pipelined 40-bit signed divider.
// It extends the operands, sends one operation at a time, and handles divide-by-zero, flush and a lost result.
module div_issue_ctrl #(
  parameter int LATENCY = 45,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_kill,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_hi,
  output logic [31:0] resp_lo,
  output logic        resp_dbz,
  output logic        div_diviend_valid,
  output logic        div_divisor_valid,
  output logic [39:0] div_diviend_bits,
  output logic [39:0] div_divisor_bits,
  input  logic        div_dout_valid,
  input  logic [79:0] div_dout_bits,
  output logic        busy,
  output logic        err
);

  // state | meaning
  // IDLE  | waiting for a request
  // BUSY  | operation in the divider, result wanted
  // DRAIN | operation killed, waiting for the divider to flush it out
  // DONE  | response held until the consumer takes it

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

  // An illegal TIMEOUT would fire before a nominal result could arrive, so it is clamped.
  localparam int TMO = (TIMEOUT > LATENCY + 1) ? TIMEOUT : LATENCY + 2;
  localparam int CW  = $clog2(TMO + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          timeout;
  logic          unused_dout;

  assign req_ready   = (state == IDLE) & ~req_kill;
  assign accept      = req_valid & req_ready;
  assign busy        = (state != IDLE);
  assign timeout     = (cnt == CW'(TMO - 1));
  assign unused_dout = ^{div_dout_bits[79:72], div_dout_bits[39:32]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      err               <= 1'b0;
      resp_valid        <= 1'b0;
      resp_hi           <= '0;
      resp_lo           <= '0;
      resp_dbz          <= 1'b0;
      div_diviend_valid <= 1'b0;
      div_divisor_valid <= 1'b0;
      div_diviend_bits  <= '0;
      div_divisor_bits  <= '0;
    end else begin
      div_diviend_valid <= 1'b0;
      div_divisor_valid <= 1'b0;
      if (div_dout_valid && (state == IDLE || state == DONE))
        err <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            div_diviend_bits <= req_signed ? {{8{req_a[31]}}, req_a} : {8'h00, req_a};
            div_divisor_bits <= req_signed ? {{8{req_b[31]}}, req_b} : {8'h00, req_b};
            cnt              <= '0;
            if (req_b != 32'd0) begin
              div_diviend_valid <= 1'b1;
              div_divisor_valid <= 1'b1;
              state             <= BUSY;
            end else begin
              resp_hi    <= req_a;
              resp_lo    <= 32'hFFFF_FFFF;
              resp_dbz   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= DONE;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (div_dout_valid) begin
            // A kill landing with the result discards it; the divider is already empty.
            if (req_kill) begin
              state <= IDLE;
            end else begin
              resp_lo    <= div_dout_bits[71:40];
              resp_hi    <= div_dout_bits[31:0];
              resp_dbz   <= 1'b0;
              resp_valid <= 1'b1;
              state      <= DONE;
            end
          end else if (timeout) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (req_kill) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          cnt <= cnt + 1'b1;
          if (div_dout_valid) begin
            state <= IDLE;
          end else if (timeout) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        DONE: begin
          if (req_kill || resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: a behavioural divider pipeline plus a response scoreboard.
module tb_div_issue_ctrl;
  localparam int LAT = 45;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_signed = 1'b0, req_kill = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_ready, resp_valid, resp_dbz, busy, err;
  logic [31:0] resp_hi, resp_lo;
  logic        div_diviend_valid, div_divisor_valid;
  logic [39:0] div_diviend_bits, div_divisor_bits;
  logic        div_dout_valid;
  logic [79:0] div_dout_bits;

  logic           model_on = 1'b1;
  logic           inj_v = 1'b0;
  logic [79:0]    inj_bits = '0;
  logic [LAT-1:0] pv;
  logic [79:0]    pd [LAT];

  int checks = 0;
  int failures = 0;
  logic [64:0] exp_q[$];

  div_issue_ctrl #(.LATENCY(45), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_a(req_a), .req_b(req_b), .req_kill(req_kill),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hi(resp_hi), .resp_lo(resp_lo), .resp_dbz(resp_dbz),
    .div_diviend_valid(div_diviend_valid), .div_divisor_valid(div_divisor_valid),
    .div_diviend_bits(div_diviend_bits), .div_divisor_bits(div_divisor_bits),
    .div_dout_valid(div_dout_valid), .div_dout_bits(div_dout_bits),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] divres(input logic [39:0] a, input logic [39:0] b);
    logic signed [39:0] q, r;
    if (b == 40'd0) return '0;
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {q, r};
  endfunction

  // Divider: samples at the edge ending the valid cycle, answers LAT cycles later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], model_on & div_diviend_valid};
      pd[0] <= divres(div_diviend_bits, div_divisor_bits);
      for (int i = LAT - 1; i > 0; i--) pd[i] <= pd[i-1];
    end
  end

  assign div_dout_valid = pv[LAT-1] | inj_v;
  assign div_dout_bits  = inj_v ? inj_bits : pd[LAT-1];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every delivered response is popped and compared.
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready && !req_kill) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {resp_dbz, resp_hi, resp_lo}, 80'h0);
      end else begin
        chk("resp", {resp_dbz, resp_hi, resp_lo}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Issue one request and wait for resp_valid; returns in the first cycle resp_valid is seen.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                       input int elat, input logic push);
    int n;
    logic [39:0] ea, eb;
    ea = s ? {{8{a[31]}}, a} : {8'h00, a};
    eb = s ? {{8{b[31]}}, b} : {8'h00, b};
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_signed = s; req_a = a; req_b = b;
    if (push) exp_q.push_back({edbz, ehi, elo});
    tick();
    req_valid = 1'b0;
    n = 1;
    if (b != 0) begin
      chk("issue_valid", {div_diviend_valid, div_divisor_valid}, 2'b11);
      chk("issue_bits", {div_diviend_bits, div_divisor_bits}, {ea, eb});
      tick(); n++;
      chk("issue_pulse_end", {div_diviend_valid, div_divisor_valid}, 2'b00);
    end else begin
      chk("dbz_no_issue", {div_diviend_valid, div_divisor_valid}, 2'b00);
    end
    while (!resp_valid && n < 120) begin
      tick(); n++;
    end
    chk("resp_latency", n, elat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic ok;
    logic [31:0] hh, ll;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset_ready", req_ready, 1);
    chk("reset_outs", {resp_valid, busy, err, resp_dbz, div_diviend_valid, div_divisor_valid}, 6'b0);
    chk("reset_data", {resp_hi, resp_lo, div_diviend_bits}, 104'h0);

    issue(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 47, 1'b1);
    tick();
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 47, 1'b1);
    tick();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 47, 1'b1);
    tick();
    issue(1'b0, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'h7FFF_FFFF, 1'b0, 47, 1'b1);
    tick();
    issue(1'b1, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1, 1, 1'b1);
    tick();

    // Kill ten cycles after accept: busy until the divider drains, no response.
    req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd77; req_b = 32'd3;
    tick();
    req_valid = 1'b0;
    n = 1;
    while (n < 10) begin tick(); n++; end
    req_kill = 1'b1;
    tick(); n++;
    req_kill = 1'b0;
    ok = 1'b1;
    while (n < 46) begin
      if (!busy || resp_valid) ok = 1'b0;
      tick(); n++;
    end
    chk("drain_busy", {ok, busy, resp_valid}, 3'b110);
    tick();
    chk("drain_done", {req_ready, busy, resp_valid}, 3'b100);
    issue(1'b0, 32'd50, 32'd5, 32'd0, 32'd10, 1'b0, 47, 1'b1);
    tick();

    // Back-pressure with a spurious divider result in DONE.
    resp_ready = 1'b0;
    issue(1'b0, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, 47, 1'b1);
    hh = resp_hi; ll = resp_lo;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!resp_valid || resp_hi !== 32'd1 || resp_lo !== 32'd2 || resp_dbz || req_ready) ok = 1'b0;
      inj_v = (i == 5); inj_bits = 80'hDEAD_BEEF_0000_CAFE_F00D;
      tick();
    end
    inj_v = 1'b0;
    chk("hold_stable", {ok, resp_hi, resp_lo}, {1'b1, 32'd1, 32'd2});
    chk("spurious_done_err", err, 1);
    resp_ready = 1'b1;
    tick();
    chk("hold_release", {req_ready, busy, resp_valid}, 3'b100);

    // Kill wins over resp_ready in DONE.
    resp_ready = 1'b0;
    issue(1'b0, 32'h55, 32'd0, 32'h55, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
    req_kill = 1'b1; resp_ready = 1'b1;
    #1;
    chk("kill_done_ready", req_ready, 0);
    tick();
    req_kill = 1'b0;
    chk("kill_done", {resp_valid, busy}, 2'b00);

    // Lost result: timeout raises err and returns to IDLE with no response.
    do_reset();
    chk("reset2_err", {err, busy}, 2'b00);
    model_on = 1'b0;
    req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd1; req_b = 32'd1;
    tick();
    req_valid = 1'b0;
    n = 1;
    ok = 1'b1;
    while (!err && n < 80) begin
      if (resp_valid || (n <= 62 && !busy)) ok = 1'b0;
      tick(); n++;
    end
    chk("timeout_window", (n >= 63 && n <= 66), 1);
    chk("timeout_state", {ok, err, busy, resp_valid}, 4'b1100);
    model_on = 1'b1;

    // Spurious result in IDLE.
    do_reset();
    chk("reset3_err", err, 0);
    inj_v = 1'b1; inj_bits = 80'h1;
    tick();
    inj_v = 1'b0;
    chk("spurious_idle", {err, resp_valid, busy}, 3'b100);

    tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
